unidade_controle: RTL
=====================

# unidade_controle

Multi-cycle control unit for the 8-bit accumulator CPU datapath. It latches the 4-bit opcode from the instruction bus and sequences one instruction at a time through the following states: IDLE, FETCH, EXEC, MEM, HALT and the optional STEP. For each instruction it drives `ld_ac`, `ac_src`, `pc_src`, a PC update enable and the data-memory handshake. It sits beside the datapath, takes `opcode` and an accumulator-zero flag from it, and gates every architectural state change.

## Interface
- No parameters. Widths are fixed: opcode 4 bits, instruction counter 8 bits.

Ports:
- `clock`  in  1  — single system clock, rising edge.
- `reset`  in  1  — asynchronous, active-high; forces IDLE.
- `start`  in  1  — level; sampled in IDLE only.
- `opcode`  in  4  — `instMemDataBus[7:4]` from the datapath.
- `ac_zero`  in  1  — 1 when `acOut == 8'h00`.
- `dm_ready`  in  1  — data memory completes the current access this cycle.
- `step`  in  1  — single-step advance; used only with `CTRL_STEP_EN`.
- `ld_ac`  out  1  — accumulator load.
- `ac_src`  out  1  — 0 selects the ALU result, 1 selects data-memory data.
- `pc_src`  out  1  — 0 selects PC+1, 1 selects the instruction address field.
- `pc_en`  out  1  — PC register update enable.
- `dm_req`  out  1  — data-memory access pending.
- `dm_we`  out  1  — data-memory write strobe.
- `halted`  out  1  — high in HALT.
- `illegal`  out  1  — sticky flag: an undefined opcode was executed.
- `instr_count`  out  8  — number of retired instructions.

## Operation
Opcode map:
- 0 NOP
- 1 LDA
- 2 STA
- 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOT — the ALU class
- 9 JMP
- A JZ
- F HLT
- B–E undefined

Outputs are combinational from the state and the latched opcode register `ir_op`. All outputs are 0 unless listed below.

State behaviour:
- **IDLE**: if `start`=1, go to FETCH.
- **FETCH**: `ir_op <= opcode`, then go to EXEC. `pc_en`=0.
- **EXEC**, by `ir_op`:
  - ALU class: `ld_ac`=1, `ac_src`=0, `pc_en`=1. Retire, go to FETCH.
  - NOP or undefined: `pc_en`=1. Retire, go to FETCH. Undefined opcodes also set `illegal`.
  - LDA and STA: `dm_req`=1.
    - If `dm_ready`=1: complete in this cycle (see completion rules below), retire, go to FETCH.
    - Otherwise go to MEM.
  - JMP: `pc_src`=1, `pc_en`=1. Retire, go to FETCH.
  - JZ: `pc_src`=`ac_zero`, `pc_en`=1. Retire, go to FETCH.
  - HLT: retire, go to HALT. `pc_en`=0.
- **MEM**: `dm_req`=1. Wait for `dm_ready`=1, then complete, retire, and go to FETCH. There is no timeout.
- **HALT**: `halted`=1. The state is left only by `reset`.

Memory completion rules:
- LDA: `ld_ac`=1, `ac_src`=1, `pc_en`=1.
- STA: `dm_we`=1, `pc_en`=1.

Retire rule:
- `instr_count` increments by 1 in every retiring cycle.
- It wraps from 255 to 0.

## Timing
- Reset values:
  - state IDLE, `ir_op`=0, `instr_count`=0, `illegal`=0.
  - All strobes 0 and `halted`=0.
  - Because outputs decode the state, strobes drop immediately on reset assertion, including mid-MEM.
- Instruction latency:
  - 2 cycles for non-memory instructions (FETCH + EXEC).
  - 2 + N cycles for LDA/STA, where N is the number of cycles `dm_ready` stays low after EXEC.
- `start` is ignored outside IDLE.
- `dm_ready` is ignored unless `dm_req`=1.
- `pc_en` is high for exactly one cycle per retired non-HLT instruction.
- `dm_we` is high for exactly one cycle per STA.
- `opcode` must be stable in FETCH. A change on `opcode` during EXEC or MEM has no effect.
- `ac_zero` is sampled combinationally in the JZ EXEC cycle.

## Configuration
- **`CTRL_STEP_EN` defined**:
  - Every retiring transition that would enter FETCH enters STEP instead.
  - STEP drives all outputs 0 and waits for `step`=1, then goes to FETCH.
  - `step` is level-sensitive: holding it high yields continuous run with one extra cycle per instruction.
- **`CTRL_STEP_EN` not defined**:
  - The STEP state and its logic are absent.
  - The `step` port exists but is ignored.
  - Behaviour is exactly as described under Operation.

## Test plan
- **ALU retire**: reset, `start`=1, `opcode`=3 (ADD) → cycle 2 shows `ld_ac`=1, `ac_src`=0, `pc_en`=1, `pc_src`=0; `instr_count`=1.
- **Delayed LDA**: `opcode`=1 with `dm_ready` held low for 3 cycles → `dm_req` high for 4 cycles; a single `ld_ac`=1/`ac_src`=1/`pc_en`=1 pulse in the `dm_ready` cycle; total 5 cycles.
- **JZ both paths**: `opcode`=A with `ac_zero`=1 → `pc_src`=1, `pc_en`=1; repeat with `ac_zero`=0 → `pc_src`=0, `pc_en`=1.
- **HLT and illegal opcode**: `opcode`=C → `illegal` sets and stays 1, `pc_en` pulses; then `opcode`=F → `halted`=1 and `pc_en` stays 0 for 20 cycles, even with `start`/`dm_ready` toggling.
- **Reset mid-STA**: assert `reset` while in MEM → `dm_req`/`dm_we` drop without waiting for a clock edge; `instr_count`=0; state IDLE.
- **Counter wrap, and step mode with `CTRL_STEP_EN`**: 256 NOPs → `instr_count` wraps to 0. With the macro defined and `step`=0 after the first NOP retires, no further `pc_en` occurs until `step` is pulsed.

Source files
------------

// File: rtl/unidade_controle.sv
// Multi-cycle control unit for the 8-bit accumulator CPU: FETCH/EXEC/MEM/HALT sequencing.
// Define CTRL_STEP_EN to insert a STEP state that holds each retired instruction until step=1.
module unidade_controle (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] opcode,
   input  logic       ac_zero,
   input  logic       dm_ready,
   input  logic       step,
   output logic       ld_ac,
   output logic       ac_src,
   output logic       pc_src,
   output logic       pc_en,
   output logic       dm_req,
   output logic       dm_we,
   output logic       halted,
   output logic       illegal,
   output logic [7:0] instr_count
);

   localparam logic [3:0] OpLda = 4'h1;
   localparam logic [3:0] OpSta = 4'h2;
   localparam logic [3:0] OpAdd = 4'h3;
   localparam logic [3:0] OpNot = 4'h8;
   localparam logic [3:0] OpJmp = 4'h9;
   localparam logic [3:0] OpJz  = 4'hA;
   localparam logic [3:0] OpUndefLo = 4'hB;
   localparam logic [3:0] OpUndefHi = 4'hE;
   localparam logic [3:0] OpHlt = 4'hF;

`ifdef CTRL_STEP_EN
   typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StHalt, StStep} state_t;
   localparam state_t StAfterRetire = StStep;
`else
   typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StHalt} state_t;
   localparam state_t StAfterRetire = StFetch;
   logic unusedStep;
   assign unusedStep = step;
`endif

   state_t     state;
   logic [3:0] irOp;
   logic       isMem;
   logic       isAlu;
   logic       isUndef;
   logic       retire;

   assign isMem   = (irOp == OpLda) || (irOp == OpSta);
   assign isAlu   = (irOp >= OpAdd) && (irOp <= OpNot);
   assign isUndef = (irOp >= OpUndefLo) && (irOp <= OpUndefHi);

   // A memory instruction retires in the first cycle that dm_ready meets a pending request.
   assign retire = ((state == StExec) && (!isMem || dm_ready)) ||
                   ((state == StMem) && dm_ready);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= StIdle;
         irOp        <= 4'h0;
         instr_count <= 8'h00;
         illegal     <= 1'b0;
      end else begin
         if (retire) begin
            instr_count <= instr_count + 8'd1;
         end
         case (state)
            StIdle: begin
               if (start) begin
                  state <= StFetch;
               end
            end
            StFetch: begin
               irOp  <= opcode;
               state <= StExec;
            end
            StExec: begin
               if (isUndef) begin
                  illegal <= 1'b1;
               end
               if (irOp == OpHlt) begin
                  state <= StHalt;
               end else if (isMem && !dm_ready) begin
                  state <= StMem;
               end else begin
                  state <= StAfterRetire;
               end
            end
            StMem: begin
               if (dm_ready) begin
                  state <= StAfterRetire;
               end
            end
            StHalt: begin
               state <= StHalt;
            end
`ifdef CTRL_STEP_EN
            StStep: begin
               if (step) begin
                  state <= StFetch;
               end
            end
`endif
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   // Outputs decode state and irOp only, so they collapse as soon as reset forces IDLE.
   always_comb begin
      ld_ac  = 1'b0;
      ac_src = 1'b0;
      pc_src = 1'b0;
      pc_en  = 1'b0;
      dm_req = 1'b0;
      dm_we  = 1'b0;
      halted = 1'b0;
      case (state)
         StExec, StMem: begin
            if (isMem) begin
               dm_req = 1'b1;
               if (dm_ready) begin
                  pc_en = 1'b1;
                  if (irOp == OpLda) begin
                     ld_ac  = 1'b1;
                     ac_src = 1'b1;
                  end else begin
                     dm_we = 1'b1;
                  end
               end
            end else if (state == StExec) begin
               if (isAlu) begin
                  ld_ac = 1'b1;
                  pc_en = 1'b1;
               end else if (irOp == OpJmp) begin
                  pc_src = 1'b1;
                  pc_en  = 1'b1;
               end else if (irOp == OpJz) begin
                  pc_src = ac_zero;
                  pc_en  = 1'b1;
               end else if (irOp != OpHlt) begin
                  pc_en = 1'b1;
               end
            end
         end
         StHalt: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
